// File: rtl/log_perf_if.sv
// Bundle of perf-counter inputs, logging-window status and the snapshot stream.
// The bench drives through master; log_perf_ctrl attaches as slave.
interface log_perf_if #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 48,
  parameter int unsigned INC_W   = 6,
  parameter int unsigned IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
);
  logic [NUM_CNT*INC_W-1:0] perf_inc;
  logic [63:0]              log_begin;
  logic [63:0]              log_end;
  logic [31:0]              dump_period;
  logic                     auto_clean;
  logic                     dump_req;
  logic                     clean_req;
  logic [63:0]              timer;
  logic                     logEnable;
  logic                     clean;
  logic                     dump;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_idx;
  logic [CNT_W-1:0]         out_data;
  logic                     out_last;
  logic                     dump_overrun;

  modport master (
    output perf_inc, log_begin, log_end, dump_period, auto_clean, dump_req,
           clean_req, out_ready,
    input  timer, logEnable, clean, dump, out_valid, out_idx, out_data,
           out_last, dump_overrun
  );

  modport slave (
    input  perf_inc, log_begin, log_end, dump_period, auto_clean, dump_req,
           clean_req, out_ready,
    output timer, logEnable, clean, dump, out_valid, out_idx, out_data,
           out_last, dump_overrun
  );
endinterface

// File: rtl/log_perf_ctrl.sv
// Windowed saturating perf-counter bank with periodic/external snapshot dump
// streamed out one channel per beat over a valid/ready handshake.
module log_perf_ctrl #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 48,
  parameter int unsigned INC_W   = 6,
  parameter int unsigned IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input logic       clock,
  input logic       reset,
  log_perf_if.slave bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_nxt;
  logic [63:0]      timer_q;
  logic [31:0]      period_cnt;
  logic [31:0]      period_last;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             dump_q, dump_nxt;
  logic             overrun, overrun_nxt;
  logic             clean_q;
  logic             snap;
  logic             log_en;
  logic             period_chg;
  logic             auto_req;
  logic             dump_rq;
  logic             last_beat;
  logic [CNT_W-1:0] acc    [NUM_CNT];
  logic [CNT_W-1:0] shadow [NUM_CNT];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign log_en     = (timer_q >= bus.log_begin) && (timer_q < bus.log_end);
  assign period_chg = (bus.dump_period != period_last);
  assign auto_req   = (bus.dump_period != 32'd0) && !period_chg &&
                      (period_cnt == bus.dump_period - 32'd1);
  assign dump_rq    = bus.dump_req | auto_req;
  assign last_beat  = (idx == IDX_W'(NUM_CNT - 1));

  // Free-running timer and auto-dump period counter (restarts on period change)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q     <= 64'd0;
      period_cnt  <= 32'd0;
      period_last <= 32'd0;
    end else begin
      timer_q     <= timer_q + 64'd1;
      period_last <= bus.dump_period;
      if (period_chg || (bus.dump_period == 32'd0) || auto_req)
        period_cnt <= 32'd0;
      else
        period_cnt <= period_cnt + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      dump_q  <= 1'b0;
      overrun <= 1'b0;
      clean_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      dump_q  <= dump_nxt;
      overrun <= overrun_nxt;
      clean_q <= bus.clean_req | (bus.auto_clean & dump_q);
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    dump_nxt    = 1'b0;
    overrun_nxt = overrun;
    snap        = 1'b0;
    case (state)
      IDLE: begin
        if (dump_rq) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
          dump_nxt  = 1'b1;
          snap      = 1'b1;
        end
      end
      STREAM: begin
        if (dump_rq) overrun_nxt = 1'b1;
        if (bus.out_ready) begin
          if (last_beat) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot takes the pre-increment value; clean wins over that cycle's increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        acc[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        if (clean_q)
          acc[i] <= '0;
        else if (log_en)
          acc[i] <= sat_add(acc[i], bus.perf_inc[i*INC_W +: INC_W]);
        if (snap) shadow[i] <= acc[i];
      end
    end
  end

  assign bus.timer        = timer_q;
  assign bus.logEnable    = log_en;
  assign bus.clean        = clean_q;
  assign bus.dump         = dump_q;
  assign bus.out_valid    = (state == STREAM);
  assign bus.out_idx      = idx;
  assign bus.out_data     = shadow[idx];
  assign bus.out_last     = (state == STREAM) && last_beat;
  assign bus.dump_overrun = overrun;

endmodule

// File: tb/tb_log_perf_ctrl.sv
// Directed bench for log_perf_ctrl: expected beats are queued at dump time and a
// forked monitor pops/compares every accepted beat and checks stall stability.
module tb_log_perf_ctrl;
  localparam int unsigned NC = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 6;
  localparam int unsigned XW = 3;

  typedef struct {
    logic [XW-1:0] idx;
    logic [CW-1:0] data;
    logic          last;
  } beat_t;

  logic  clk;
  logic  rst_n;
  int    compared;
  int    mismatched;
  int    tmodel;
  beat_t exp_q[$];

  log_perf_if #(.NUM_CNT(NC), .CNT_W(CW), .INC_W(IW), .IDX_W(XW)) bus ();

  log_perf_ctrl #(.NUM_CNT(NC), .CNT_W(CW), .INC_W(IW), .IDX_W(XW)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      tmodel++;
    end
    #1;
  endtask

  task automatic push(input int idx, input int data);
    beat_t b;
    b.idx  = XW'(idx);
    b.data = CW'(data);
    b.last = (idx == int'(NC) - 1);
    exp_q.push_back(b);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
      step(1);
      n++;
    end
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, 64'(bus.out_valid), 64'd0);
  endtask

  // Monitor: pops one expected beat per accepted transfer; checks hold while stalled
  task automatic monitor();
    logic          held;
    logic [XW-1:0] hidx;
    logic [CW-1:0] hdata;
    beat_t         b;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (held && bus.out_valid) begin
        chk("hold_idx", 64'(bus.out_idx), 64'(hidx));
        chk("hold_data", 64'(bus.out_data), 64'(hdata));
      end
      held  = bus.out_valid && !bus.out_ready;
      hidx  = bus.out_idx;
      hdata = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL extra_beat: got idx %0d data %0d expected no beat", bus.out_idx, bus.out_data);
        end else begin
          b = exp_q.pop_front();
          chk("beat_idx", 64'(bus.out_idx), 64'(b.idx));
          chk("beat_data", 64'(bus.out_data), 64'(b.data));
          chk("beat_last", 64'(bus.out_last), 64'(b.last));
        end
      end
    end
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    tmodel          = 0;
    rst_n           = 1'b0;
    bus.perf_inc    = '0;
    bus.log_begin   = 64'd0;
    bus.log_end     = 64'd0;
    bus.dump_period = 32'd0;
    bus.auto_clean  = 1'b0;
    bus.dump_req    = 1'b0;
    bus.clean_req   = 1'b0;
    bus.out_ready   = 1'b1;
    fork monitor(); join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_timer", bus.timer, 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_dump", 64'(bus.dump), 64'd0);
    chk("rst_clean", 64'(bus.clean), 64'd0);
    chk("rst_overrun", 64'(bus.dump_overrun), 64'd0);
    chk("rst_logen", 64'(bus.logEnable), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    tmodel = 0;
    step(5);
    chk("timer_run", bus.timer, 64'd5);

    // Logging window [T+10, T+20): channel i adds i+1 per cycle
    bus.log_begin = 64'(tmodel + 10);
    bus.log_end   = 64'(tmodel + 20);
    for (int i = 0; i < int'(NC); i++) bus.perf_inc[i*IW +: IW] = IW'(i + 1);
    step(9);
    chk("le_before", 64'(bus.logEnable), 64'd0);
    step(1);
    chk("le_first", 64'(bus.logEnable), 64'd1);
    step(9);
    chk("le_last", 64'(bus.logEnable), 64'd1);
    step(1);
    chk("le_after", 64'(bus.logEnable), 64'd0);
    chk("overrun_clear", 64'(bus.dump_overrun), 64'd0);
    bus.dump_req = 1'b1;
    step(1);
    bus.dump_req = 1'b0;
    chk("dump_ext", 64'(bus.dump), 64'd1);
    for (int i = 0; i < int'(NC); i++) push(i, 10 * (i + 1));
    step(1);
    chk("dump_pulse_end", 64'(bus.dump), 64'd0);
    drain("window");

    // Stalled stream with out_ready toggling, plus an overrun request
    bus.out_ready = 1'b0;
    bus.dump_req  = 1'b1;
    step(1);
    bus.dump_req = 1'b0;
    chk("dump_stall", 64'(bus.dump), 64'd1);
    for (int i = 0; i < int'(NC); i++) push(i, 10 * (i + 1));
    for (int k = 0; k < 30; k++) begin
      bus.out_ready = (k % 2 == 1);
      if (k == 3) bus.dump_req = 1'b1;
      step(1);
      if (k == 3) begin
        bus.dump_req = 1'b0;
        chk("overrun_nodump", 64'(bus.dump), 64'd0);
        chk("overrun_set", 64'(bus.dump_overrun), 64'd1);
      end
    end
    bus.out_ready = 1'b1;
    drain("stall");

    // Saturation: all channels +63 for 10 cycles, then dump with auto_clean
    bus.log_begin = 64'(tmodel + 1);
    bus.log_end   = 64'(tmodel + 11);
    for (int i = 0; i < int'(NC); i++) bus.perf_inc[i*IW +: IW] = IW'(63);
    step(12);
    bus.auto_clean = 1'b1;
    bus.dump_req   = 1'b1;
    step(1);
    bus.dump_req = 1'b0;
    chk("dump_sat", 64'(bus.dump), 64'd1);
    for (int i = 0; i < int'(NC); i++) push(i, 255);
    step(1);
    chk("auto_clean", 64'(bus.clean), 64'd1);
    bus.auto_clean = 1'b0;
    drain("sat");

    // clean_req in an enabled cycle discards that increment: 5 adds of 1 remain
    for (int i = 0; i < int'(NC); i++) bus.perf_inc[i*IW +: IW] = IW'(1);
    bus.log_begin = 64'(tmodel + 1);
    bus.log_end   = 64'(tmodel + 7);
    bus.clean_req = 1'b1;
    step(1);
    bus.clean_req = 1'b0;
    chk("clean_req", 64'(bus.clean), 64'd1);
    step(1);
    chk("clean_once", 64'(bus.clean), 64'd0);
    step(6);
    bus.dump_req = 1'b1;
    step(1);
    bus.dump_req = 1'b0;
    for (int i = 0; i < int'(NC); i++) push(i, 5);
    drain("clean");

    // Auto-dump every 100 cycles
    bus.dump_period = 32'd100;
    step(100);
    chk("auto_early", 64'(bus.dump), 64'd0);
    step(1);
    chk("auto_dump1", 64'(bus.dump), 64'd1);
    for (int i = 0; i < int'(NC); i++) push(i, 5);
    step(99);
    chk("auto_gap", 64'(bus.dump), 64'd0);
    step(1);
    chk("auto_dump2", 64'(bus.dump), 64'd1);
    for (int i = 0; i < int'(NC); i++) push(i, 5);
    bus.dump_period = 32'd0;
    drain("auto");
    chk("overrun_sticky", 64'(bus.dump_overrun), 64'd1);

    // Reset while beat 3 is presented
    bus.dump_req = 1'b1;
    step(1);
    bus.dump_req = 1'b0;
    for (int i = 0; i < 3; i++) push(i, 5);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_timer", bus.timer, 64'd0);
    chk("arst_overrun", 64'(bus.dump_overrun), 64'd0);
    chk("arst_idx", 64'(bus.out_idx), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    tmodel = 0;
    step(3);
    chk("post_rst_timer", bus.timer, 64'd3);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_q", 64'(exp_q.size()), 64'd0);
    bus.dump_req = 1'b1;
    step(1);
    bus.dump_req = 1'b0;
    for (int i = 0; i < int'(NC); i++) push(i, 0);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
